// File: rtl/riscv_muldiv.sv
// riscv_muldiv -- iterative RV32M multiply/divide unit for the execute stage.
//
// Multiply is a shift-add over a 2*WIDTH accumulator and takes WIDTH cycles.
// Divide is restoring, one quotient bit per cycle, and also takes WIDTH cycles.
// Divide-by-zero and signed-overflow divides finish in one cycle.
// The result register changes only on completion, so it is held until the
// next operation completes.
//
// Optional feature macro: RISCV_MULDIV_FAST_MUL_EN. When it is defined, all
// four multiplies use a combinational 2*WIDTH product and finish in one cycle.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-low reset
//   start   in   request; accepted only in IDLE or DONE
//   funct3  in   RV32M operation select
//   a, b    in   rs1 / rs2 operands, sampled with start
//   flush   in   abort in-flight op; also drops a same-cycle start
//   busy    out  high while iterating
//   done    out  one-cycle completion pulse
//   result  out  answer, held between completions
module riscv_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
   state_t state, state_nxt;

   logic [2*WIDTH-1:0] acc;       // {hi/remainder, lo/quotient}
   logic [WIDTH-1:0]   opb;       // multiplicand / divisor magnitude
   logic [CW-1:0]      cnt;
   logic [1:0]         op;        // funct3[1:0] of the op in flight
   logic               neg_lo;    // negate product / quotient at the end
   logic               neg_r;     // negate remainder at the end

   logic accept, last;
   assign accept = start & ~flush & ((state == S_IDLE) | (state == S_DONE));
   assign last   = (cnt == CW'(WIDTH - 1));

   // ---------------- request decode ----------------
   logic             is_div, a_sgn, b_sgn, div0, ovf, special;
   logic [WIDTH-1:0] mag_a, mag_b, spec_res;

   always_comb begin
      is_div  = funct3[2];
      // MUL (000) is treated as unsigned; its low word does not depend on sign
      a_sgn   = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
      b_sgn   = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
      mag_a   = (a_sgn & a[WIDTH-1]) ? -a : a;
      mag_b   = (b_sgn & b[WIDTH-1]) ? -b : b;
      div0    = is_div && (b == '0);
      ovf     = is_div && ~funct3[0] && (a == MOST_NEG) && (b == '1);
      special = div0 | ovf;
      if (div0) spec_res = funct3[1] ? a : '1;
      else      spec_res = funct3[1] ? '0 : a;
   end

`ifdef RISCV_MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] ea, eb, fprod;
   logic [WIDTH-1:0]   fast_res;
   always_comb begin
      ea       = {{WIDTH{a_sgn & a[WIDTH-1]}}, a};
      eb       = {{WIDTH{b_sgn & b[WIDTH-1]}}, b};
      fprod    = ea * eb;
      fast_res = (funct3[1:0] == 2'b00) ? fprod[WIDTH-1:0] : fprod[2*WIDTH-1:WIDTH];
   end
`endif

   // ---------------- iteration step ----------------
   logic [WIDTH:0]     mul_sum, rem_sh;
   logic [WIDTH-1:0]   sub, quo, rem, mul_res, div_res, fin_res;
   logic [2*WIDTH-1:0] acc_mul, acc_div, prod;
   logic               q_bit;

   always_comb begin
      // shift-add: add multiplicand into the high half when the current
      // multiplier bit (acc[0]) is set, then shift the whole thing right
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      acc_mul = {mul_sum, acc[WIDTH-1:1]};
      // restoring divide: shift the next dividend bit into the remainder and
      // subtract when it fits; the difference then fits in WIDTH bits
      rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      q_bit   = (rem_sh >= {1'b0, opb});
      sub     = rem_sh[WIDTH-1:0] - opb;
      acc_div = {(q_bit ? sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};

      prod    = neg_lo ? -acc_mul : acc_mul;
      mul_res = (op == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      quo     = acc_div[WIDTH-1:0];
      rem     = acc_div[2*WIDTH-1:WIDTH];
      div_res = op[1] ? (neg_r ? -rem : rem) : (neg_lo ? -quo : quo);
      fin_res = (state == S_DIV) ? div_res : mul_res;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            state_nxt = S_IDLE;
            if (accept) begin
               if (special)        state_nxt = S_DONE;
               else if (is_div)    state_nxt = S_DIV;
               else begin
`ifdef RISCV_MULDIV_FAST_MUL_EN
                  state_nxt = S_DONE;
`else
                  state_nxt = S_MUL;
`endif
               end
            end
         end
         S_MUL, S_DIV: begin
            // flush beats the final iteration edge
            if (flush)     state_nxt = S_IDLE;
            else if (last) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_MUL) || (state == S_DIV);
      done = (state == S_DONE);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc    <= '0;
         opb    <= '0;
         cnt    <= '0;
         op     <= '0;
         neg_lo <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
      end else if (accept) begin
         acc    <= {{WIDTH{1'b0}}, mag_a};
         opb    <= mag_b;
         cnt    <= '0;
         op     <= funct3[1:0];
         neg_lo <= (a_sgn & a[WIDTH-1]) ^ (b_sgn & b[WIDTH-1]);
         neg_r  <= a_sgn & a[WIDTH-1];
         if (special) result <= spec_res;
`ifdef RISCV_MULDIV_FAST_MUL_EN
         else if (!is_div) result <= fast_res;
`endif
      end else if (busy && !flush) begin
         acc <= (state == S_DIV) ? acc_div : acc_mul;
         cnt <= cnt + CW'(1);
         if (last) result <= fin_res;
      end
   end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv (WIDTH=32). Expected results are pushed
// to a scoreboard queue at issue time and popped by a monitor on each done.
module tb_riscv_muldiv;
   localparam int W = 32;
`ifdef RISCV_MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic         clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
   logic [2:0]   funct3 = '0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done;
   logic [W-1:0] result;

   int           n_chk = 0, n_fail = 0;
   logic [W-1:0] sb[$];

   riscv_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .result(result));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model built on 64-bit integer arithmetic
   function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy;
      longint unsigned ux, uy, p;
      logic ov;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = ux * uy; return p[W-1:0]; end
         3'd1: begin p = longint'(sx * sy); return p[2*W-1:W]; end
         3'd2: begin p = longint'(sx * longint'(uy)); return p[2*W-1:W]; end
         3'd3: begin p = ux * uy; return p[2*W-1:W]; end
         3'd4: return (y == 0) ? '1 : ov ? x : W'(sx / sy);
         3'd5: return (y == 0) ? '1 : x / y;
         3'd6: return (y == 0) ? x : ov ? '0 : W'(sx % sy);
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int op_lat(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
      if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
      if (!f[2] && FAST) return 1;
      return W + 1;
   endfunction

   // call right after a negedge; the following posedge samples the request
   task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp, input bit push, output int lat);
      start = 1'b1; funct3 = f; a = x; b = y;
      if (push) sb.push_back(exp);
      lat = op_lat(f, x, y);
   endtask

   // checks busy/done for cycles 1..n; optional flush or stray start pulse
   task automatic watch(input int lat, input int n, input int flush_at, input int pulse_at);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         chk("busy", W'(busy), W'(lat > 1 && c <= W && (flush_at == 0 || c <= flush_at)));
         chk("done", W'(done), W'(c == lat && flush_at == 0));
         start = (c == pulse_at);
         flush = (c == flush_at);
         if (c == pulse_at) begin funct3 = 3'b101; a = 32'd99; b = 32'd7; end
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset && done) begin
         if (sb.size() == 0) chk("spurious_done", W'(done), '0);
         else chk("result", result, sb.pop_front());
      end
   end

   // hard stop in case something stalls the sequence
   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [2:0]   ftab [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
   logic [W-1:0] atab [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC,
                               32'hFFFF_FFEC, 32'd20, 32'd20, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [W-1:0] btab [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,
                               32'd3, 32'd3, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [W-1:0] etab [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
                               32'hFFFF_FFFE, 32'd6, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

   initial begin
      int lat;
      logic [2:0]   f;
      logic [W-1:0] x, y, held;

      // reset state
      #2 reset = 1'b0;
      #1;
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_result", result, '0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // directed operations from the plan, including the special cases
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         issue(ftab[i], atab[i], btab[i], etab[i], 1'b1, lat);
         watch(lat, lat, 0, 0);
      end

      // random operands against the model
      for (int i = 0; i < 10; i++) begin
         f = 3'($urandom_range(0, 7));
         x = $urandom;
         y = $urandom;
         if (i % 3 == 0) y = y & 32'h0000_000F;
         @(negedge clk);
         issue(f, x, y, model(f, x, y), 1'b1, lat);
         watch(lat, lat, 0, 0);
      end

      // start while busy ignored, then back-to-back start in the done cycle
      @(negedge clk);
      issue(3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b1, lat);
      watch(lat, lat, 0, 10);
      issue(3'd5, 32'd20, 32'd3, 32'd6, 1'b1, lat);
      watch(lat, lat, 0, 0);
      @(negedge clk);
      chk("result_held", result, 32'd6);

      // flush mid-operation: no done, result unchanged
      held = 32'd6;
      @(negedge clk);
      issue(FAST ? 3'd5 : 3'd0, 32'd100, 32'd7, '0, 1'b0, lat);
      watch(lat, W + 4, 5, 0);
      chk("flush_result", result, held);

      // flush on the final iteration edge
      @(negedge clk);
      issue(3'd7, 32'd100, 32'd7, '0, 1'b0, lat);
      watch(lat, W + 4, W, 0);
      chk("flush_last_result", result, held);

      // start together with flush is dropped
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'd5; a = 32'd5; b = 32'd0;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("drop_busy", W'(busy), '0);
      @(negedge clk);
      chk("drop_done", W'(done), '0);

      // reset mid-operation
      @(negedge clk);
      issue(3'd5, 32'd1000, 32'd10, '0, 1'b0, lat);
      watch(lat, 11, 0, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst_busy", W'(busy), '0);
      chk("midrst_done", W'(done), '0);
      chk("midrst_result", result, '0);
      @(negedge clk);
      reset = 1'b1;
      repeat (W + 4) begin
         @(negedge clk);
         chk("postrst_done", W'(done), '0);
      end

      chk("sb_empty", W'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative RV32M multiply/divide unit parametrised in operand width, sitting beside the single-cycle ALU in the execute stage of the multicycle and pipelined core variants. It accepts one operation per start pulse and computes it over a bounded number of cycles using a shift-add multiplier and a restoring divider. It returns a one-cycle done pulse with a held result. It implements the RISC-V special cases (divide by zero, signed overflow) with early completion.

## Interface
- WIDTH, 32: operand and result width in bits; must be even and ≥ 4.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; while low, all state is cleared.
- start  in  1  request; sampled only in IDLE or DONE.
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand; sampled with start.
- b  in  WIDTH  rs2 operand; sampled with start.
- flush  in  1  abort in-flight operation (pipeline kill).
- busy  out  1  high while iterating; start ignored.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  answer; held from done until next accepted start.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE/DONE + start → latch funct3, a, b.
  - Special case → DONE.
  - funct3[2]=0 → MUL.
  - Otherwise → DIV.
- Special cases, which apply to the divide ops only:
  - Divide by zero (b=0): DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (DIV/REM, a=most-negative, b=all-ones): DIV gives a; REM gives 0.
- MUL state:
  - Operands are converted to magnitudes. a is signed for MULH and MULHSU. b is signed for MULH only. MUL uses the low word, which is sign-agnostic.
  - One shift-add step per cycle over a 2·WIDTH accumulator, WIDTH steps, iteration counter 0..WIDTH-1.
  - At the end, the product is negated if the operand signs differ.
  - MUL returns low WIDTH bits. MULH/MULHSU/MULHU return high WIDTH bits.
- DIV state:
  - Magnitudes are used for DIV/REM.
  - Restoring division, one quotient bit per cycle, WIDTH steps.
  - Signed quotient is negated if the signs differ.
  - Signed remainder takes the sign of a.
- DONE: done=1 for exactly one cycle. Without start, the next state is IDLE.
- flush:
  - In MUL/DIV → IDLE next edge. No done; result unchanged.
  - In IDLE/DONE: no effect on state. flush with start in the same cycle drops the start.
- start while busy is ignored (no queueing).
- All arithmetic is modulo 2^WIDTH. Intermediate negation uses two's complement of the full accumulator.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, counters 0.
- Cycle numbering: start sampled at the end of cycle 0.
- Iterative op:
  - busy=1 in cycles 1..WIDTH.
  - done=1 and result valid in cycle WIDTH+1.
  - Latency is WIDTH+1.
- Special case: busy stays 0; done=1 in cycle 1.
- Back-to-back: start during the done cycle is accepted. No idle bubble, so throughput is one op per WIDTH+1 cycles.
- Reset asserted mid-operation: everything returns to reset values immediately. No done.
- flush and the final iteration edge in the same cycle: flush wins. No done.

## Configuration
- RISCV_MULDIV_FAST_MUL_EN:
  - Defined: MUL/MULH/MULHSU/MULHU use a combinational 2·WIDTH product. The MUL state is bypassed, giving done in cycle 1 with busy never high. Divide is unchanged.
  - Undefined: iterative multiply as above, with no hardware multiplier inferred.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3), WIDTH=32 → result 0xFFFFFFEB; busy cycles 1–32; done only in cycle 33 (cycle 1 with the fast macro).
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA; REM −20/3 → 0xFFFFFFFE; DIVU 20/3 → 6; REMU 20/3 → 2; each with done in cycle 33.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0; each with done in cycle 1 and busy never high.
- Start a DIV, pulse start with new operands in cycle 10 → ignored, original result delivered in cycle 33. Start again in cycle 33 → accepted, done in cycle 66.
- Start a MUL, assert flush in cycle 5 → IDLE in cycle 6, no done, result unchanged. Separately, drive reset low in cycle 12 → busy, done and result immediately 0.
